// File: rtl/wb_lsu_master.sv
// Wishbone classic master: one CPU load/store per bus cycle, with alignment check and load extension.
// Define LSU_TIMEOUT_EN to build the ack watchdog (TIMEOUT_CYCLES bus cycles without ack -> error).
module wb_lsu_master #(
  parameter int WB_DATA_WIDTH  = 32,
  parameter int WB_ADDR_WIDTH  = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_n_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic                     req_we_i,
  input  logic [1:0]               req_size_i,
  input  logic                     req_unsigned_i,
  input  logic [WB_ADDR_WIDTH-1:0] req_addr_i,
  input  logic [WB_DATA_WIDTH-1:0] req_wdata_i,
  output logic                     rsp_valid_o,
  output logic                     rsp_err_o,
  output logic [WB_DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                     wb_cyc_o,
  output logic                     wb_stb_o,
  output logic                     wb_we_o,
  output logic [WB_ADDR_WIDTH-1:0] wb_addr_o,
  output logic [3:0]               wb_sel_o,
  output logic [WB_DATA_WIDTH-1:0] wb_data_o,
  input  logic [WB_DATA_WIDTH-1:0] wb_data_i,
  input  logic                     wb_ack_i
);

  if (WB_DATA_WIDTH != 32) begin : g_bad_width
    $error("wb_lsu_master supports only WB_DATA_WIDTH = 32");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("wb_lsu_master TIMEOUT_CYCLES must be in 1..255");
  end

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUS  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]               state_reg;
  logic [1:0]               size_reg;
  logic                     unsigned_reg;
  logic [3:0]               sel_next;
  logic [WB_DATA_WIDTH-1:0] wdata_next;
  logic [WB_DATA_WIDTH-1:0] ext_data;
  logic                     misaligned;
  logic                     tmo_hit;

  assign req_ready_o = wb_rst_n_i && (state_reg == ST_IDLE);

  always_comb begin
    sel_next = 4'b1111;
    case (req_size_i)
      2'd0:    sel_next = 4'b0001;
      2'd1:    sel_next = 4'b0011;
      default: sel_next = 4'b1111;
    endcase
  end

  always_comb begin
    misaligned = 1'b0;
    case (req_size_i)
      2'd1:    misaligned = req_addr_i[0];
      2'd2:    misaligned = (req_addr_i[1:0] != 2'b00);
      2'd3:    misaligned = 1'b1;
      default: misaligned = 1'b0;
    endcase
  end

  // Store data is zero-padded above the access size, lane by lane.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign wdata_next[gi*8 +: 8] = req_wdata_i[gi*8 +: 8] & {8{sel_next[gi]}};
  end

  always_comb begin
    ext_data = wb_data_i;
    case (size_reg)
      2'd0:    ext_data = {{24{~unsigned_reg & wb_data_i[7]}}, wb_data_i[7:0]};
      2'd1:    ext_data = {{16{~unsigned_reg & wb_data_i[15]}}, wb_data_i[15:0]};
      default: ext_data = wb_data_i;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] tmo_cnt_reg;

  // Counts completed ack-less BUS cycles; zero on the first BUS cycle.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      tmo_cnt_reg <= 8'd0;
    end else if (state_reg != ST_BUS) begin
      tmo_cnt_reg <= 8'd0;
    end else if (!wb_ack_i) begin
      tmo_cnt_reg <= tmo_cnt_reg + 8'd1;
    end
  end

  assign tmo_hit = (tmo_cnt_reg == TMO_LAST);
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_reg    <= ST_IDLE;
      size_reg     <= 2'd0;
      unsigned_reg <= 1'b0;
      rsp_valid_o  <= 1'b0;
      rsp_err_o    <= 1'b0;
      rsp_rdata_o  <= '0;
      wb_cyc_o     <= 1'b0;
      wb_stb_o     <= 1'b0;
      wb_we_o      <= 1'b0;
      wb_addr_o    <= '0;
      wb_sel_o     <= 4'b0000;
      wb_data_o    <= '0;
    end else begin
      rsp_valid_o <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (req_valid_i) begin
            if (misaligned) begin
              rsp_valid_o <= 1'b1;
              rsp_err_o   <= 1'b1;
              rsp_rdata_o <= '0;
              state_reg   <= ST_RESP;
            end else begin
              wb_cyc_o     <= 1'b1;
              wb_stb_o     <= 1'b1;
              wb_we_o      <= req_we_i;
              wb_addr_o    <= req_addr_i;
              wb_sel_o     <= sel_next;
              wb_data_o    <= wdata_next;
              size_reg     <= req_size_i;
              unsigned_reg <= req_unsigned_i;
              state_reg    <= ST_BUS;
            end
          end
        end
        ST_BUS: begin
          // An ack in the expiry cycle takes priority over the watchdog.
          if (wb_ack_i) begin
            wb_cyc_o    <= 1'b0;
            wb_stb_o    <= 1'b0;
            rsp_valid_o <= 1'b1;
            rsp_err_o   <= 1'b0;
            rsp_rdata_o <= wb_we_o ? '0 : ext_data;
            state_reg   <= ST_RESP;
          end else if (tmo_hit) begin
            wb_cyc_o    <= 1'b0;
            wb_stb_o    <= 1'b0;
            rsp_valid_o <= 1'b1;
            rsp_err_o   <= 1'b1;
            rsp_rdata_o <= '0;
            state_reg   <= ST_RESP;
          end
        end
        ST_RESP: state_reg <= ST_IDLE;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule
